// File: rtl/router_pkg.sv
// Shared types and header helpers for the router byte-serial packet protocol.
// Pure declarations: no latency, no flow control.
package router_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HDR  = 3'd1,
        ST_PLD  = 3'd2,
        ST_PAR  = 3'd3,
        ST_GAP  = 3'd4
    } state_t;

    localparam int LEN_W  = 6;
    localparam int ADDR_W = 2;
    localparam int BYTE_W = 8;

    localparam logic [ADDR_W-1:0] ADDR_INVALID = 2'b11;

    function automatic logic [BYTE_W-1:0] pack_hdr(
        input logic [LEN_W-1:0]  len,
        input logic [ADDR_W-1:0] addr
    );
        return {len, addr};
    endfunction

endpackage

// File: rtl/router_pkt_source.sv
// Descriptor-driven packet transmitter: header, payload, parity byte; header one cycle after req.
// Router busy stalls the byte on data_out in place; req is only sampled in IDLE.
module router_pkt_source
    import router_pkg::*;
#(
    parameter int IFG = 2
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              req,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [LEN_W-1:0]  req_len,
    input  logic [BYTE_W-1:0] req_seed,
    input  logic              req_bad_par,
    output logic              req_ack,
    output logic              req_rej,
    input  logic              busy,
    output logic              pkt_valid,
    output logic [BYTE_W-1:0] data_out,
    output logic              pkt_done,
    output logic              tx_active,
    output logic [BYTE_W-1:0] parity_out
);

    localparam logic [3:0] GAP_LAST = (IFG > 0) ? 4'(IFG - 1) : 4'd0;

    state_t            state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [BYTE_W-1:0] seed_q, seed_d;
    logic              bad_q, bad_d;
    logic [BYTE_W-1:0] acc_q, acc_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic [3:0]        gap_q, gap_d;

    logic              req_ack_q, req_ack_d;
    logic              req_rej_q, req_rej_d;
    logic              pkt_valid_q, pkt_valid_d;
    logic [BYTE_W-1:0] data_out_q, data_out_d;
    logic              pkt_done_q, pkt_done_d;
    logic              tx_active_q, tx_active_d;
    logic [BYTE_W-1:0] parity_out_q, parity_out_d;

    logic [BYTE_W-1:0] acc_nxt;
    logic [BYTE_W-1:0] hdr;

    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        seed_d       = seed_q;
        bad_d        = bad_q;
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        gap_d        = gap_q;
        req_ack_d    = 1'b0;
        req_rej_d    = 1'b0;
        pkt_done_d   = 1'b0;
        pkt_valid_d  = pkt_valid_q;
        data_out_d   = data_out_q;
        parity_out_d = parity_out_q;
        acc_nxt      = acc_q;
        hdr          = pack_hdr(req_len, req_addr);

        unique case (state_q)
            ST_IDLE: begin
                if (req) begin
                    if (req_addr == ADDR_INVALID) begin
                        req_rej_d = 1'b1;
                    end else begin
                        req_ack_d   = 1'b1;
                        len_d       = req_len;
                        seed_d      = req_seed;
                        bad_d       = req_bad_par;
                        acc_d       = hdr;
                        data_out_d  = hdr;
                        pkt_valid_d = 1'b1;
                        state_d     = ST_HDR;
                    end
                end
            end
            ST_HDR: begin
                if (!busy) begin
                    if (len_q == '0) begin
                        state_d     = ST_PAR;
                        pkt_valid_d = 1'b0;
                        data_out_d  = bad_q ? ~acc_q : acc_q;
                    end else begin
                        state_d    = ST_PLD;
                        cnt_d      = '0;
                        data_out_d = seed_q;
                    end
                end
            end
            ST_PLD: begin
                if (!busy) begin
                    // Fold the byte leaving this edge so the parity byte is ready next cycle.
                    acc_nxt = acc_q ^ data_out_q;
                    acc_d   = acc_nxt;
                    if (cnt_q == len_q - 6'd1) begin
                        state_d     = ST_PAR;
                        pkt_valid_d = 1'b0;
                        data_out_d  = bad_q ? ~acc_nxt : acc_nxt;
                    end else begin
                        cnt_d      = cnt_q + 6'd1;
                        data_out_d = data_out_q + 8'd1;
                    end
                end
            end
            ST_PAR: begin
                if (!busy) begin
                    pkt_done_d   = 1'b1;
                    parity_out_d = data_out_q;
                    data_out_d   = '0;
                    gap_d        = '0;
                    state_d      = (IFG == 0) ? ST_IDLE : ST_GAP;
                end
            end
            ST_GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q + 4'd1;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                pkt_valid_d = 1'b0;
                data_out_d  = '0;
            end
        endcase

        tx_active_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= ST_IDLE;
            len_q        <= '0;
            seed_q       <= '0;
            bad_q        <= 1'b0;
            acc_q        <= '0;
            cnt_q        <= '0;
            gap_q        <= '0;
            req_ack_q    <= 1'b0;
            req_rej_q    <= 1'b0;
            pkt_valid_q  <= 1'b0;
            data_out_q   <= '0;
            pkt_done_q   <= 1'b0;
            tx_active_q  <= 1'b0;
            parity_out_q <= '0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            seed_q       <= seed_d;
            bad_q        <= bad_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            gap_q        <= gap_d;
            req_ack_q    <= req_ack_d;
            req_rej_q    <= req_rej_d;
            pkt_valid_q  <= pkt_valid_d;
            data_out_q   <= data_out_d;
            pkt_done_q   <= pkt_done_d;
            tx_active_q  <= tx_active_d;
            parity_out_q <= parity_out_d;
        end
    end

    assign req_ack    = req_ack_q;
    assign req_rej    = req_rej_q;
    assign pkt_valid  = pkt_valid_q;
    assign data_out   = data_out_q;
    assign pkt_done   = pkt_done_q;
    assign tx_active  = tx_active_q;
    assign parity_out = parity_out_q;

endmodule

// File: tb/tb_router_pkt_source.sv
// Bench for router_pkt_source: scenario tasks plus a byte/parity scoreboard fed from descriptors.
module tb_router_pkt_source;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       req = 1'b0;
    logic [1:0] req_addr = '0;
    logic [5:0] req_len = '0;
    logic [7:0] req_seed = '0;
    logic       req_bad_par = 1'b0;
    logic       req_ack, req_rej;
    logic       busy = 1'b0;
    logic       pkt_valid;
    logic [7:0] data_out;
    logic       pkt_done, tx_active;
    logic [7:0] parity_out;

    int n_cmp = 0;
    int n_err = 0;

    logic [8:0] exp_q[$];
    logic [7:0] par_q[$];
    bit         in_pkt = 1'b0;

    router_pkt_source #(.IFG(2)) dut (
        .clk(clk), .rstn(rstn),
        .req(req), .req_addr(req_addr), .req_len(req_len), .req_seed(req_seed),
        .req_bad_par(req_bad_par), .req_ack(req_ack), .req_rej(req_rej),
        .busy(busy), .pkt_valid(pkt_valid), .data_out(data_out),
        .pkt_done(pkt_done), .tx_active(tx_active), .parity_out(parity_out)
    );

    always #5 clk = ~clk;

    // Scoreboard: a byte is consumed on every non-busy cycle from the header through the parity byte.
    always @(negedge clk) begin
        logic [8:0] e;
        logic [7:0] p;
        if (!rstn) begin
            in_pkt = 1'b0;
        end else begin
            if (pkt_valid) in_pkt = 1'b1;
            if (in_pkt && !busy) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL sb_extra_byte: got valid=%0b data=%02h, none expected", pkt_valid, data_out);
                    in_pkt = 1'b0;
                end else begin
                    e = exp_q.pop_front();
                    if ({pkt_valid, data_out} !== e) begin
                        n_err++;
                        $display("FAIL sb_byte: got valid=%0b data=%02h, want valid=%0b data=%02h",
                                 pkt_valid, data_out, e[8], e[7:0]);
                    end
                    if (!e[8]) in_pkt = 1'b0;
                end
            end
            if (pkt_done) begin
                n_cmp++;
                if (par_q.size() == 0) begin
                    n_err++;
                    $display("FAIL sb_extra_done: pkt_done with parity_out=%02h, none expected", parity_out);
                end else begin
                    p = par_q.pop_front();
                    if (parity_out !== p) begin
                        n_err++;
                        $display("FAIL sb_parity_out: got %02h want %02h", parity_out, p);
                    end
                end
            end
        end
    end

    task automatic push_pkt(input logic [1:0] a, input logic [5:0] l, input logic [7:0] s, input bit bad);
        logic [7:0] acc, b;
        acc = {l, a};
        exp_q.push_back({1'b1, acc});
        b = s;
        for (int i = 0; i < int'(l); i++) begin
            exp_q.push_back({1'b1, b});
            acc = acc ^ b;
            b = b + 8'd1;
        end
        if (bad) acc = ~acc;
        exp_q.push_back({1'b0, acc});
        par_q.push_back(acc);
    endtask

    // Presents one descriptor for a single sampling edge; returns at posedge+1 after that edge.
    task automatic send_req(input logic [1:0] a, input logic [5:0] l, input logic [7:0] s, input bit bad);
        @(posedge clk); #1;
        req = 1'b1; req_addr = a; req_len = l; req_seed = s; req_bad_par = bad;
        @(posedge clk); #1;
        req = 1'b0;
    endtask

    task automatic wait_done(output int cyc, output bit ok);
        cyc = 0;
        ok  = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            cyc++;
            if (pkt_done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic test_reset;
        #3;
        n_cmp++;
        if ({req_ack, req_rej, pkt_valid, data_out, pkt_done, tx_active, parity_out} !== 21'd0) begin
            n_err++;
            $display("FAIL reset_outputs: got ack=%0b rej=%0b vld=%0b data=%02h done=%0b act=%0b par=%02h, want all 0",
                     req_ack, req_rej, pkt_valid, data_out, pkt_done, tx_active, parity_out);
        end
        idle(2); #1;
        rstn = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (tx_active !== 1'b0 || pkt_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_idle: got act=%0b vld=%0b want 0 0", tx_active, pkt_valid);
        end
    endtask

    task automatic test_nominal;
        int cyc; bit ok;
        push_pkt(2'd2, 6'd5, 8'h00, 1'b0);
        send_req(2'd2, 6'd5, 8'h00, 1'b0);
        @(negedge clk);
        n_cmp++;
        if (req_ack !== 1'b1 || pkt_valid !== 1'b1 || data_out !== 8'h16 || tx_active !== 1'b1) begin
            n_err++;
            $display("FAIL nom_header: got ack=%0b vld=%0b data=%02h act=%0b want 1 1 16 1",
                     req_ack, pkt_valid, data_out, tx_active);
        end
        wait_done(cyc, ok);
        n_cmp++;
        if (!ok || cyc != 7) begin
            n_err++;
            $display("FAIL nom_length: got done=%0b after %0d cycles, want done after 7", ok, cyc);
        end
        n_cmp++;
        if (parity_out !== 8'h12) begin
            n_err++;
            $display("FAIL nom_parity: got %02h want 12", parity_out);
        end
        @(negedge clk);
        n_cmp++;
        if (pkt_done !== 1'b0 || tx_active !== 1'b1 || parity_out !== 8'h12) begin
            n_err++;
            $display("FAIL nom_gap: got done=%0b act=%0b par=%02h want 0 1 12", pkt_done, tx_active, parity_out);
        end
        @(negedge clk);
        n_cmp++;
        if (tx_active !== 1'b0) begin
            n_err++;
            $display("FAIL nom_idle_after_gap: got act=%0b want 0", tx_active);
        end
    endtask

    task automatic test_back_to_back;
        int cyc, first, second; bit ok;
        push_pkt(2'd0, 6'd3, 8'hFE, 1'b0);
        push_pkt(2'd0, 6'd3, 8'hFE, 1'b0);
        @(posedge clk); #1;
        req = 1'b1; req_addr = 2'd0; req_len = 6'd3; req_seed = 8'hFE; req_bad_par = 1'b0;
        first = -1; second = -1; cyc = 0;
        for (int i = 0; i < 60 && second < 0; i++) begin
            @(negedge clk);
            cyc++;
            if (req_ack) begin
                if (first < 0) first = cyc;
                else second = cyc;
            end
        end
        @(posedge clk); #1;
        req = 1'b0;
        n_cmp++;
        if (first < 0 || second < 0 || second - first != 8) begin
            n_err++;
            $display("FAIL b2b_spacing: got acks at %0d and %0d, want spacing 8", first, second);
        end
        wait_done(cyc, ok);
        n_cmp++;
        if (!ok || parity_out !== 8'h0D) begin
            n_err++;
            $display("FAIL b2b_parity: got done=%0b par=%02h want 1 0d", ok, parity_out);
        end
        idle(4);
    endtask

    task automatic test_backpressure;
        int cyc; bit ok;
        push_pkt(2'd2, 6'd5, 8'h00, 1'b0);
        send_req(2'd2, 6'd5, 8'h00, 1'b0);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (data_out !== 8'h01 || pkt_valid !== 1'b1) begin
            n_err++;
            $display("FAIL bp_pre: got vld=%0b data=%02h want 1 01", pkt_valid, data_out);
        end
        @(posedge clk); #1;
        busy = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_cmp++;
            if (data_out !== 8'h02 || pkt_valid !== 1'b1) begin
                n_err++;
                $display("FAIL bp_hold: busy cycle %0d got vld=%0b data=%02h want 1 02", k, pkt_valid, data_out);
            end
            @(posedge clk);
        end
        #1;
        busy = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (data_out !== 8'h03) begin
            n_err++;
            $display("FAIL bp_resume: got data=%02h want 03", data_out);
        end
        wait_done(cyc, ok);
        n_cmp++;
        if (!ok || cyc != 3) begin
            n_err++;
            $display("FAIL bp_length: got done=%0b %0d cycles after 0x03, want done after 3 (10-cycle packet)", ok, cyc);
        end
        idle(4);
    endtask

    task automatic test_zero_len;
        int cyc; bit ok;
        push_pkt(2'd1, 6'd0, 8'h55, 1'b0);
        send_req(2'd1, 6'd0, 8'h55, 1'b0);
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (pkt_valid !== 1'b0 || data_out !== 8'h01) begin
            n_err++;
            $display("FAIL zl_parity_byte: got vld=%0b data=%02h want 0 01", pkt_valid, data_out);
        end
        wait_done(cyc, ok);
        n_cmp++;
        if (!ok || cyc != 1 || parity_out !== 8'h01) begin
            n_err++;
            $display("FAIL zl_done: got done=%0b cyc=%0d par=%02h want 1 1 01", ok, cyc, parity_out);
        end
        idle(4);
    endtask

    task automatic test_bad_parity;
        int cyc; bit ok;
        push_pkt(2'd2, 6'd5, 8'h00, 1'b1);
        send_req(2'd2, 6'd5, 8'h00, 1'b1);
        wait_done(cyc, ok);
        n_cmp++;
        if (!ok || parity_out !== 8'hED) begin
            n_err++;
            $display("FAIL badpar: got done=%0b par=%02h want 1 ed", ok, parity_out);
        end
        idle(4);
    endtask

    task automatic test_invalid_addr;
        send_req(2'd3, 6'd4, 8'h10, 1'b0);
        @(negedge clk);
        n_cmp++;
        if (req_rej !== 1'b1 || req_ack !== 1'b0 || pkt_valid !== 1'b0 || tx_active !== 1'b0) begin
            n_err++;
            $display("FAIL inv_rej: got rej=%0b ack=%0b vld=%0b act=%0b want 1 0 0 0",
                     req_rej, req_ack, pkt_valid, tx_active);
        end
        @(negedge clk);
        n_cmp++;
        if (req_rej !== 1'b0 || tx_active !== 1'b0 || pkt_valid !== 1'b0) begin
            n_err++;
            $display("FAIL inv_after: got rej=%0b act=%0b vld=%0b want 0 0 0", req_rej, tx_active, pkt_valid);
        end
    endtask

    task automatic test_reset_mid;
        int cyc; bit ok;
        push_pkt(2'd2, 6'd5, 8'h00, 1'b0);
        send_req(2'd2, 6'd5, 8'h00, 1'b0);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (data_out !== 8'h01) begin
            n_err++;
            $display("FAIL rst_mid_pre: got data=%02h want 01", data_out);
        end
        #1;
        rstn = 1'b0;
        #1;
        n_cmp++;
        if (pkt_valid !== 1'b0 || data_out !== 8'h00 || tx_active !== 1'b0) begin
            n_err++;
            $display("FAIL rst_mid_async: got vld=%0b data=%02h act=%0b want 0 00 0", pkt_valid, data_out, tx_active);
        end
        exp_q.delete();
        par_q.delete();
        @(negedge clk);
        @(posedge clk); #1;
        rstn = 1'b1;
        idle(2);
        push_pkt(2'd2, 6'd5, 8'h00, 1'b0);
        send_req(2'd2, 6'd5, 8'h00, 1'b0);
        @(negedge clk);
        n_cmp++;
        if (req_ack !== 1'b1 || data_out !== 8'h16 || pkt_valid !== 1'b1) begin
            n_err++;
            $display("FAIL rst_mid_restart: got ack=%0b data=%02h vld=%0b want 1 16 1", req_ack, data_out, pkt_valid);
        end
        wait_done(cyc, ok);
        n_cmp++;
        if (!ok || parity_out !== 8'h12) begin
            n_err++;
            $display("FAIL rst_mid_parity: got done=%0b par=%02h want 1 12", ok, parity_out);
        end
        idle(4);
    endtask

    initial begin
        test_reset();
        test_nominal();
        idle(3);
        test_back_to_back();
        test_backpressure();
        test_zero_len();
        test_bad_parity();
        test_invalid_addr();
        test_reset_mid();
        @(negedge clk);
        n_cmp++;
        if (exp_q.size() != 0 || par_q.size() != 0) begin
            n_err++;
            $display("FAIL sb_drain: %0d bytes and %0d parities still expected, want 0 0", exp_q.size(), par_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/router_pkt_source.md
# router_pkt_source

Packet transmitter for the router input port. It accepts a packet descriptor (address, payload length, payload seed) from an upstream requester. It then drives the router's byte-serial input protocol: header byte, payload bytes, and a trailing parity byte with pkt_valid low. It honours the router's busy back-pressure and is used both as a synthesizable traffic source and as the stimulus engine for router-level benches.

## Interface

Parameters:
- IFG, default 2: idle cycles inserted after each packet's parity byte before the next descriptor is sampled. Legal range is 0..15.

Ports:
- clk, in, 1: single clock. All logic is rising-edge.
- rstn, in, 1: asynchronous, active-low reset.
- req, in, 1: descriptor valid.
- req_addr, in, 2: destination port. Values 0..2 are legal; 3 is invalid.
- req_len, in, 6: payload byte count, 0..63.
- req_seed, in, 8: first payload byte. Payload byte i = (req_seed + i) mod 256.
- req_bad_par, in, 1: when 1, the packet is sent with inverted parity (error injection).
- req_ack, out, 1: one-cycle pulse, descriptor accepted.
- req_rej, out, 1: one-cycle pulse, descriptor rejected (addr = 3).
- busy, in, 1: router back-pressure. When 1, the current byte is not transferred.
- pkt_valid, out, 1: high during header and payload bytes, low during the parity byte.
- data_out, out, 8: byte to the router.
- pkt_done, out, 1: one-cycle pulse after the parity byte is transferred.
- tx_active, out, 1: high whenever the state is not IDLE.
- parity_out, out, 8: parity actually sent. Held until the next pkt_done.

## Operation

- States: IDLE, HDR, PLD, PAR, GAP.
- All outputs are registered (Moore).
- Reset values: state = IDLE; all outputs are 0, including data_out and parity_out.
- Transfer rule: in HDR, PLD or PAR, a byte transfers on a rising edge where busy = 0.
  - While busy = 1, state, data_out, pkt_valid and the payload counter hold unchanged.
- IDLE: on a rising edge with req = 1:
  - addr 0..2: capture the descriptor, pulse req_ack, go to HDR.
  - addr 3: pulse req_rej, stay in IDLE, capture nothing.
- HDR:
  - data_out = {len, addr}, pkt_valid = 1.
  - The parity accumulator loads the header byte.
  - On transfer: go to PAR if len = 0, else go to PLD with cnt = 0.
- PLD:
  - data_out = seed + cnt (8-bit wrap), pkt_valid = 1.
  - On transfer: acc ^= byte and cnt++.
  - The transfer with cnt = len − 1 goes to PAR.
- PAR:
  - pkt_valid = 0.
  - data_out = acc, or ~acc if bad_par was captured.
  - On transfer: pulse pkt_done, latch parity_out = sent byte, go to GAP (or to IDLE if IFG = 0).
- GAP: count IFG cycles, then go to IDLE. req is ignored in GAP.
- busy is ignored in IDLE and GAP.
- Reset mid-packet: all outputs drop to reset values immediately (asynchronous) and the descriptor is discarded. No partial parity is emitted.

## Timing

- req is sampled at edge t. In cycle t+1, req_ack = 1 and the header is on data_out with pkt_valid = 1.
- Upstream may change req the cycle after it sees req_ack. No double capture is possible because the state is no longer IDLE.
- Packet length with busy = 0 throughout: len + 2 cycles (header, payload, parity). pkt_done is high in the cycle after the parity transfer edge.
- Header-to-header spacing with continuous req: len + 3 + IFG cycles. The 3 covers header, parity and one IDLE sampling cycle.
- Each busy cycle during a byte adds exactly one cycle to the packet.
- Payload seed wrap: seed 0xFE with len 3 gives 0xFE, 0xFF, 0x00.

## Structure

- Shared package router_pkg holds:
  - The state enum.
  - ADDR_INVALID = 2'b11.
  - Header field widths: LEN_W = 6, ADDR_W = 2, BYTE_W = 8.
  - A header-pack function {len, addr}.
- Single module. The FSM, payload counter, IFG counter and parity accumulator are small enough that no sub-module is warranted.

## Test plan

- Nominal packet: addr = 2, len = 5, seed = 0, IFG = 2, busy = 0.
  - data_out is 0x16, 0x00, 0x01, 0x02, 0x03, 0x04, then parity 0x12 with pkt_valid low.
  - pkt_done pulses once and parity_out = 0x12.
- Back-pressure: same packet with busy = 1 for 3 cycles while payload byte 0x02 is presented.
  - 0x02 is held for 4 cycles, with no duplicated or skipped byte.
  - Total packet length is 10 cycles.
  - Final parity is 0x12.
- Zero length: addr = 1, len = 0, seed = 0x55.
  - Output is header 0x01, then parity 0x01. No payload cycles.
- Error injection: nominal packet with req_bad_par = 1.
  - Parity byte and parity_out are 0xED.
- Invalid address: req with addr = 3.
  - req_rej pulses one cycle after sampling and req_ack stays 0.
  - pkt_valid stays 0 and the state remains IDLE.
- Reset mid-payload: rstn is driven low while 0x01 is presented.
  - pkt_valid, data_out and tx_active go to 0 before the next edge.
  - After release, a new nominal packet starts cleanly with header 0x16.
